// File: rtl/cordic_iter.sv
// Iterative CORDIC: one micro-rotation per cycle, rotation or vectoring mode,
// quadrant pre-mapping, gain compensation and output saturation.
module cordic_iter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 13,
  parameter int ITERS = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    sat,
  output logic                    err
);
  localparam int DW = WIDTH + 2;
  localparam int PW = 2 * DW;
  localparam int CW = $clog2(ITERS + 1);
  localparam real SCALE_F = 2.0 ** FRAC;

  function automatic logic signed [DW-1:0] to_fix(input real v);
    return DW'($rtoi(v * SCALE_F + 0.5));
  endfunction

  function automatic real gain_inv();
    real k;
    k = 1.0;
    for (int i = 0; i < ITERS; i++) k = k / $sqrt(1.0 + 2.0 ** (-2.0 * i));
    return k;
  endfunction

  localparam logic signed [DW-1:0] PI_C      = to_fix(3.14159265358979);
  localparam logic signed [DW-1:0] HALF_PI_C = to_fix(1.57079632679490);
  localparam logic signed [DW-1:0] K_C       = to_fix(gain_inv());
  localparam logic signed [PW-1:0] RND  = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [PW-1:0] MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, DONE} state_t;

  state_t state_reg, state_next;
  logic signed [DW-1:0] x_reg, y_reg, z_reg;
  logic [CW-1:0] iter_reg;
  logic mode_reg, err_reg, zero_reg;
  logic signed [WIDTH-1:0] x_out_reg, y_out_reg, z_out_reg;
  logic sat_reg, err_out_reg, out_valid_reg;
  logic accept;

  logic signed [DW-1:0] atan_tab [ITERS];
  generate
    for (genvar gi = 0; gi < ITERS; gi++) begin : g_atan
      localparam logic signed [DW-1:0] ATAN_C = to_fix($atan(1.0 / (2.0 ** gi)));
      assign atan_tab[gi] = ATAN_C;
    end
  endgenerate

  assign in_ready  = reset && (state_reg == IDLE || (state_reg == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign x_out     = x_out_reg;
  assign y_out     = y_out_reg;
  assign z_out     = z_out_reg;
  assign sat       = sat_reg;
  assign err       = err_out_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = PRE;
      PRE:     state_next = ITER;
      ITER:    if (iter_reg == CW'(ITERS - 1)) state_next = SCALE;
      SCALE:   state_next = DONE;
      DONE:    if (accept) state_next = PRE;
               else if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fold the operand into the CORDIC convergence range (|angle| <= pi/2).
  logic signed [DW-1:0] pre_x, pre_y, pre_z;
  logic pre_err, pre_zero;
  always_comb begin
    pre_x = x_reg;
    pre_y = y_reg;
    pre_z = z_reg;
    pre_err = 1'b0;
    pre_zero = 1'b0;
    if (mode_reg) begin
      if (z_reg > PI_C || z_reg < -PI_C) begin
        pre_err = 1'b1;
        pre_z = '0;
      end else if (z_reg > HALF_PI_C) begin
        pre_x = -y_reg;
        pre_y = x_reg;
        pre_z = z_reg - HALF_PI_C;
      end else if (z_reg < -HALF_PI_C) begin
        pre_x = y_reg;
        pre_y = -x_reg;
        pre_z = z_reg + HALF_PI_C;
      end
    end else begin
      pre_zero = (x_reg == '0) && (y_reg == '0);
      if (!x_reg[DW-1]) begin
        pre_z = '0;
      end else if (!y_reg[DW-1]) begin
        pre_x = y_reg;
        pre_y = -x_reg;
        pre_z = HALF_PI_C;
      end else begin
        pre_x = -y_reg;
        pre_y = x_reg;
        pre_z = -HALF_PI_C;
      end
    end
  end

  logic signed [DW-1:0] x_sh, y_sh, it_x, it_y, it_z;
  logic d_pos;
  always_comb begin
    x_sh  = x_reg >>> iter_reg;
    y_sh  = y_reg >>> iter_reg;
    d_pos = mode_reg ? ~z_reg[DW-1] : y_reg[DW-1];
    it_x  = d_pos ? x_reg - y_sh : x_reg + y_sh;
    it_y  = d_pos ? y_reg + x_sh : y_reg - x_sh;
    it_z  = d_pos ? z_reg - atan_tab[iter_reg] : z_reg + atan_tab[iter_reg];
  end

  logic signed [PW-1:0] px, py, rx, ry;
  logic signed [WIDTH-1:0] sx, sy;
  logic sat_x, sat_y;
  always_comb begin
    px = x_reg * K_C;
    py = y_reg * K_C;
    rx = (px + RND) >>> FRAC;
    ry = (py + RND) >>> FRAC;
    sat_x = (rx > MAXV) || (rx < MINV);
    sat_y = (ry > MAXV) || (ry < MINV);
    sx = (rx > MAXV) ? MAXV[WIDTH-1:0] : (rx < MINV) ? MINV[WIDTH-1:0] : rx[WIDTH-1:0];
    sy = (ry > MAXV) ? MAXV[WIDTH-1:0] : (ry < MINV) ? MINV[WIDTH-1:0] : ry[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      iter_reg      <= '0;
      mode_reg      <= 1'b0;
      err_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      x_out_reg     <= '0;
      y_out_reg     <= '0;
      z_out_reg     <= '0;
      sat_reg       <= 1'b0;
      err_out_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE: if (accept) begin
          x_reg    <= {{2{x_in[WIDTH-1]}}, x_in};
          y_reg    <= {{2{y_in[WIDTH-1]}}, y_in};
          z_reg    <= {{2{z_in[WIDTH-1]}}, z_in};
          mode_reg <= mode;
        end
        PRE: begin
          x_reg    <= pre_x;
          y_reg    <= pre_y;
          z_reg    <= pre_z;
          err_reg  <= pre_err;
          zero_reg <= pre_zero;
          iter_reg <= '0;
        end
        ITER: begin
          x_reg    <= it_x;
          y_reg    <= it_y;
          z_reg    <= it_z;
          iter_reg <= iter_reg + CW'(1);
        end
        default: ;
      endcase
      // Outputs only carry data while valid; they clear as the result retires.
      if (state_reg == SCALE) begin
        x_out_reg     <= sx;
        y_out_reg     <= sy;
        z_out_reg     <= zero_reg ? '0 : z_reg[WIDTH-1:0];
        sat_reg       <= sat_x || sat_y;
        err_out_reg   <= err_reg;
        out_valid_reg <= 1'b1;
      end else if (state_reg == DONE && (accept || out_ready)) begin
        x_out_reg     <= '0;
        y_out_reg     <= '0;
        z_out_reg     <= '0;
        sat_reg       <= 1'b0;
        err_out_reg   <= 1'b0;
        out_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cordic_iter.sv
// Directed vector table plus hand-written backpressure and mid-operation reset sequences.
module tb_cordic_iter;
  localparam int WIDTH = 16;
  localparam int FRAC  = 13;
  localparam int ITERS = 12;
  localparam int LAT   = ITERS + 3;  // counted with the accept edge as edge 1

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, sat, err;
  logic signed [WIDTH-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic signed [WIDTH-1:0] x_out, y_out, z_out;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cordic_iter #(.WIDTH(WIDTH), .FRAC(FRAC), .ITERS(ITERS)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .sat(sat), .err(err)
  );

  typedef struct {
    logic m;
    int x, y, z;
    int ex, ey, ez;
    bit chk_z;
    int esat, eerr;
  } vec_t;
  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic drive(input logic m, input int x, input int y, input int z);
    mode = m;
    x_in = WIDTH'(x);
    y_in = WIDTH'(y);
    z_in = WIDTH'(z);
  endtask

  // Caller guarantees in_ready will be high at the next edge.
  task automatic run_op(input logic m, input int x, input int y, input int z, output int lat);
    drive(m, x, y, z);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  int lat, seen;
  int cap_x, cap_y, cap_z, cap_s;

  initial begin
    //           m     x       y       z      ex      ey      ez   chkz sat err
    vecs[0]  = '{1'b1,  8192,      0,   4289,   7094,   4096,      0, 1, 0, 0};
    vecs[1]  = '{1'b0, -8192,   8192,      0,  11585,      0,  19302, 1, 0, 0};
    vecs[2]  = '{1'b0, 30000,  30000,      0,  32767,      0,   6434, 1, 1, 0};
    vecs[3]  = '{1'b1,  8192,      0,  26000,   8192,      0,      0, 0, 0, 1};
    vecs[4]  = '{1'b0,     0,      0,      0,      0,      0,      0, 1, 0, 0};
    vecs[5]  = '{1'b1,  8192,      0,  17157,  -4096,   7094,      0, 1, 0, 0};
    vecs[6]  = '{1'b1,  8192,      0, -17157,  -4096,  -7094,      0, 1, 0, 0};
    vecs[7]  = '{1'b0, -8192,  -8192,      0,  11585,      0, -19302, 1, 0, 0};
    vecs[8]  = '{1'b0,  8192,   4096,      0,   9159,      0,   3798, 1, 0, 0};
    vecs[9]  = '{1'b1,     0,   8192,  -4289,   4096,   7094,      0, 1, 0, 0};
    vecs[10] = '{1'b1,  8192,      0,  25736,  -8192,      0,      0, 1, 0, 0};
    vecs[11] = '{1'b1,  8192,      0, -25736,  -8192,      0,      0, 1, 0, 0};
    vecs[12] = '{1'b1,     0,   8192, -26000,      0,   8192,      0, 0, 0, 1};

    repeat (3) step();
    chk("rst_in_ready", int'(in_ready), 0, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_x_out", int'(x_out), 0, 0);
    chk("rst_y_out", int'(y_out), 0, 0);
    chk("rst_z_out", int'(z_out), 0, 0);
    chk("rst_flags", int'({sat, err}), 0, 0);
    reset = 1'b1;
    #1;
    chk("idle_in_ready", int'(in_ready), 1, 0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].z, lat);
      $display("vec %0d: mode=%0d x=%0d y=%0d z=%0d -> x=%0d y=%0d z=%0d sat=%0d err=%0d lat=%0d",
               i, vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].z, x_out, y_out, z_out, sat, err, lat);
      chk($sformatf("v%0d_latency", i), lat, LAT, 0);
      chk($sformatf("v%0d_x", i), int'(x_out), vecs[i].ex, 8);
      chk($sformatf("v%0d_y", i), int'(y_out), vecs[i].ey, 8);
      if (vecs[i].chk_z) chk($sformatf("v%0d_z", i), int'(z_out), vecs[i].ez, 8);
      chk($sformatf("v%0d_sat", i), int'(sat), vecs[i].esat, 0);
      chk($sformatf("v%0d_err", i), int'(err), vecs[i].eerr, 0);
      step();
      chk($sformatf("v%0d_retired", i), int'(out_valid), 0, 0);
      chk($sformatf("v%0d_x_cleared", i), int'(x_out), 0, 0);
    end

    // Backpressure: the result must hold while a second operand waits.
    out_ready = 1'b0;
    run_op(1'b1, 8192, 0, 4289, lat);
    cap_x = int'(x_out);
    cap_y = int'(y_out);
    cap_z = int'(z_out);
    cap_s = int'({sat, err});
    chk("bp_x", cap_x, 7094, 8);
    drive(1'b0, -8192, 8192, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_valid", k), int'(out_valid), 1, 0);
      chk($sformatf("bp_hold%0d_in_ready", k), int'(in_ready), 0, 0);
      chk($sformatf("bp_hold%0d_x", k), int'(x_out), cap_x, 0);
      chk($sformatf("bp_hold%0d_y", k), int'(y_out), cap_y, 0);
      chk($sformatf("bp_hold%0d_z", k), int'(z_out), cap_z, 0);
      chk($sformatf("bp_hold%0d_flags", k), int'({sat, err}), cap_s, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", int'(in_ready), 1, 0);
    step();
    in_valid = 1'b0;
    chk("b2b_retired", int'(out_valid), 0, 0);
    chk("b2b_x_zero", int'(x_out), 0, 0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    $display("b2b: x=%0d y=%0d z=%0d lat=%0d", x_out, y_out, z_out, lat);
    chk("b2b_latency", lat, LAT, 0);
    chk("b2b_x", int'(x_out), 11585, 8);
    chk("b2b_z", int'(z_out), 19302, 8);
    step();

    // Reset while iterating: the operand is dropped and never reported.
    drive(1'b1, 8192, 0, 4289);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    chk("mid_rst_valid", int'(out_valid), 0, 0);
    chk("mid_rst_in_ready", int'(in_ready), 0, 0);
    chk("mid_rst_x", int'(x_out), 0, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_idle", int'(in_ready), 1, 0);
    seen = 0;
    for (int k = 0; k < ITERS + 6; k++) begin
      step();
      if (out_valid) seen++;
    end
    chk("mid_rst_no_output", seen, 0, 0);
    run_op(1'b1, 8192, 0, 17157, lat);
    $display("after reset: x=%0d y=%0d z=%0d lat=%0d", x_out, y_out, z_out, lat);
    chk("post_rst_latency", lat, LAT, 0);
    chk("post_rst_x", int'(x_out), -4096, 8);
    chk("post_rst_y", int'(y_out), 7094, 8);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 Parameter WIDTH, default 16: signed two's-complement width of x, y and z at the ports.
REQ-002 Parameter FRAC, default 13: fractional bits of all ports; angles are in radians at the same scale.
REQ-003 Parameter ITERS, default 12, legal range 1..WIDTH-2: number of micro-rotations.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low; the block is in reset when this is low at a rising clk edge.
REQ-006 mode  input  1  operation select, sampled at accept: 1 = rotation, 0 = vectoring.
REQ-007 in_valid  input  1  operand request.
REQ-008 in_ready  output  1  block can accept an operand this cycle.
REQ-009 x_in, y_in, z_in  input  WIDTH each  operands, signed Q(WIDTH-FRAC).FRAC.
REQ-010 out_valid  output  1  result is present on the outputs.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 x_out, y_out, z_out  output  WIDTH each  results, signed, same format as the inputs.
REQ-013 sat  output  1  x_out or y_out was clipped; qualified by out_valid.
REQ-014 err  output  1  rotation-mode |z_in| > pi; qualified by out_valid.

Function
REQ-015 The FSM SHALL have five states, IDLE, PRE, ITER, SCALE and DONE, with transitions IDLE->PRE on accept, PRE->ITER, ITER->SCALE after ITERS cycles in ITER, SCALE->DONE, and DONE->IDLE on out_ready without a new accept.
REQ-016 in_ready SHALL be high in IDLE, and also in DONE when out_ready is high; an accept is in_valid & in_ready at a rising edge, and it latches mode, x_in, y_in and z_in.
REQ-017 An accept in DONE SHALL retire the current result and go directly to PRE with the new operand.
REQ-018 Latency SHALL be fixed: out_valid rises ITERS+3 rising edges after the accept edge.
REQ-019 Throughput SHALL be at most one operation per ITERS+3 cycles.
REQ-020 The internal datapath SHALL be WIDTH+2 bits, sign-extended from the ports, so that CORDIC gain cannot overflow it.
REQ-021 Constants SHALL be computed at elaboration, rounded to the nearest LSB at FRAC: atan(2^-i) for i = 0..ITERS-1, pi, pi/2, and K = product over i of 1/sqrt(1+2^-2i).
REQ-022 In rotation mode, PRE SHALL map the operand as follows:
- |z| <= pi/2: pass unchanged.
- pi/2 < z <= pi: x = -y, y = x, z = z - pi/2.
- -pi <= z < -pi/2: x = y, y = -x, z = z + pi/2.
- |z| > pi: set err, process the operand as if z = 0.
REQ-023 In vectoring mode, PRE SHALL map the operand as follows:
- x >= 0: pass unchanged, z = 0.
- x < 0 and y >= 0: x = y, y = -x, z = pi/2.
- x < 0 and y < 0: x = -y, y = x, z = -pi/2.
REQ-024 Iteration i SHALL set d = +1 when z >= 0 in rotation mode, or when y < 0 in vectoring mode, and d = -1 otherwise.
REQ-025 Each iteration SHALL then compute x' = x - d*(y >>> i), y' = y + d*(x >>> i) and z' = z - d*atan_i, using arithmetic shifts.
REQ-026 SCALE SHALL multiply x and y by K with a full-width product, add 2^(FRAC-1) and arithmetic-shift right by FRAC.
REQ-027 SCALE SHALL saturate x and y to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set sat if either value is clipped; z is not scaled.
REQ-028 x_out, y_out, z_out, sat and err SHALL be registered and held stable while out_valid is high and out_ready is low.
REQ-029 While out_valid is low, x_out, y_out, z_out, sat and err SHALL read 0.
REQ-030 In vectoring mode with x_in = y_in = 0, the result SHALL be x = y = z = 0 with sat = err = 0.

Reset
REQ-031 On reset, the FSM SHALL go to IDLE and all data registers, x_out, y_out, z_out, out_valid, sat and err SHALL be 0.
REQ-032 in_ready SHALL be 0 during any cycle in which reset is low.
REQ-033 A reset in any state SHALL abort the operation in flight, which is never output; no accept occurs in a reset cycle.

Verification
REQ-034 Rotation: x=8192, y=0, z=4289 (pi/6), out_ready=1 -> after ITERS+3 edges x_out=7094+-8, y_out=4096+-8, z_out=0+-8, sat=err=0.
REQ-035 Vectoring in quadrant II: x=-8192, y=8192 -> x_out=11585+-8, y_out=0+-8, z_out=19302+-8 (3pi/4).
REQ-036 Saturation: vectoring with x=y=30000 -> x_out=32767, sat=1, z_out=6434+-8 (pi/4).
REQ-037 Range error: rotation with z=26000 (greater than pi = 25736), x=8192, y=0 -> err=1, x_out=8192+-8, y_out=0+-8.
REQ-038 Backpressure and back-to-back: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; then assert out_ready with in_valid=1 -> the next result appears exactly ITERS+3 edges later.
REQ-039 Reset mid-operation: drive reset low for one edge while in ITER -> IDLE and all outputs 0 after that edge, no out_valid for the aborted operand, a fresh accept completes normally.
